// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 32-bit RISC-V datapath.
// Steps one instruction at a time through IF, ID, EX, MEM and WB.
// A data access that never completes parks the controller in HALT until reset.
// Instruction fields are captured at the IF->ID edge, so all outputs come from
// registered state. The exceptions are Zero->PCSrc in EX and mem_ready->loadPC
// for a store that completes in MEM.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic        halted
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  is_r;
  logic                  is_i;
  logic                  is_lw;
  logic                  is_sw;
  logic                  is_beq;
  logic                  legal;
  logic                  r_funct7_bad;
  logic [3:0]            alu_op;

  // Register, immediate and offset fields are consumed by the datapath only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify the captured instruction and pick its ALU operation.
  always_comb begin
    is_r         = (opcode == OP_R);
    is_i         = (opcode == OP_I);
    is_lw        = (opcode == OP_LW);
    is_sw        = (opcode == OP_SW);
    is_beq       = (opcode == OP_BEQ) && (funct3 == 3'b000);
    r_funct7_bad = is_r && funct7b5;
    legal        = 1'b0;
    alu_op       = ALU_ADD;
    if (is_r || is_i) begin
      legal = 1'b1;
      case (funct3)
        3'b000: alu_op = r_funct7_bad ? ALU_SUB : ALU_ADD;
        3'b001: begin
          alu_op = ALU_SLL;
          if (funct7b5) legal = 1'b0;
        end
        3'b010: begin
          alu_op = ALU_SLT;
          if (r_funct7_bad) legal = 1'b0;
        end
        3'b011: legal = 1'b0;
        3'b100: begin
          alu_op = ALU_XOR;
          if (r_funct7_bad) legal = 1'b0;
        end
        3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110: begin
          alu_op = ALU_OR;
          if (r_funct7_bad) legal = 1'b0;
        end
        default: begin
          alu_op = ALU_AND;
          if (r_funct7_bad) legal = 1'b0;
        end
      endcase
    end else if (is_lw || is_sw) begin
      legal  = 1'b1;
      alu_op = ALU_ADD;
    end else if (is_beq) begin
      legal  = 1'b1;
      alu_op = ALU_SUB;
    end
  end

  // Choose the next state from the current state, the decode and the memory handshake.
  always_comb begin
    next_state = state;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: next_state = legal ? S_EX : S_IF;
      S_EX: begin
        if (is_beq)              next_state = S_IF;
        else if (is_lw || is_sw) next_state = S_MEM;
        else                     next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)                next_state = is_lw ? S_WB : S_IF;
        else if (wait_cnt == WAIT_MAX) next_state = S_HALT;
        else                          next_state = S_MEM;
      end
      S_WB:    next_state = S_IF;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  // Advance the state, capture the fields at IF->ID and time the memory wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IF;
      wait_cnt <= '0;
      opcode   <= '0;
      funct3   <= '0;
      funct7b5 <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IF) begin
        opcode   <= instr[6:0];
        funct3   <= instr[14:12];
        funct7b5 <= instr[30];
      end
      if (state == S_EX) begin
        wait_cnt <= '0;
      end else if (state == S_MEM && !mem_ready && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_ONE;
      end
    end
  end

  // Drive the datapath and memory controls for the current state.
  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = 4'b0000;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_ID: begin
        if (!legal) begin
          illegal = 1'b1;
          loadPC  = 1'b1;
        end
      end
      S_EX: begin
        ALUCtrl = alu_op;
        ALUSrc  = is_i || is_lw || is_sw;
        if (is_beq) begin
          loadPC = 1'b1;
          PCSrc  = Zero;
        end
      end
      S_MEM: begin
        ALUCtrl  = alu_op;
        ALUSrc   = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        loadPC   = is_sw && mem_ready;
      end
      S_WB: begin
        ALUCtrl  = alu_op;
        ALUSrc   = is_i || is_lw;
        RegWrite = 1'b1;
        loadPC   = 1'b1;
        MemToReg = is_lw;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// Each step applies inputs just after a rising edge.
// It checks the control outputs mid-cycle, then moves on to the next edge.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        mem_ready;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal;
  logic        halted;

  int vectors;
  int miscompares;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D293;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  localparam logic [12:0] QUIET = 13'b0;

  multicycle_control #(
    .MEM_WAIT_MAX(15),
    .WAIT_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr(instr),
    .Zero(Zero),
    .mem_ready(mem_ready),
    .PCSrc(PCSrc),
    .ALUSrc(ALUSrc),
    .RegWrite(RegWrite),
    .MemToReg(MemToReg),
    .ALUCtrl(ALUCtrl),
    .loadPC(loadPC),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .illegal(illegal),
    .halted(halted)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack expected control values in the same order as the observed vector.
  function automatic logic [12:0] ctl(input logic pcsrc, input logic alusrc,
                                      input logic regwrite, input logic memtoreg,
                                      input logic [3:0] alu, input logic loadpc,
                                      input logic memread, input logic memwrite,
                                      input logic ill, input logic hlt);
    return {pcsrc, alusrc, regwrite, memtoreg, alu, loadpc, memread, memwrite, ill, hlt};
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic z, input logic r);
    instr     = i;
    Zero      = z;
    mem_ready = r;
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic checkOutput(input string tag, input logic [12:0] expected);
    logic [12:0] observed;
    #2;
    observed = {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
                MemRead, MemWrite, illegal, halted};
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD: IF, ID, EX, WB
    applyStimulus(I_ADD, 1'b0, 1'b0);
    checkOutput("reset_if_add", QUIET);
    checkOutput("add_id", QUIET);
    checkOutput("add_ex", ctl(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    checkOutput("add_wb", ctl(0, 0, 1, 0, 4'b0010, 1, 0, 0, 0, 0));

    // SUB, then SRAI
    applyStimulus(I_SUB, 1'b0, 1'b0);
    checkOutput("sub_if", QUIET);
    checkOutput("sub_id", QUIET);
    checkOutput("sub_ex", ctl(0, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 0));
    checkOutput("sub_wb", ctl(0, 0, 1, 0, 4'b0110, 1, 0, 0, 0, 0));
    applyStimulus(I_SRAI, 1'b0, 1'b0);
    checkOutput("srai_if", QUIET);
    checkOutput("srai_id", QUIET);
    checkOutput("srai_ex", ctl(0, 1, 0, 0, 4'b1010, 0, 0, 0, 0, 0));
    checkOutput("srai_wb", ctl(0, 1, 1, 0, 4'b1010, 1, 0, 0, 0, 0));

    // LW with three wait cycles: 8 cycles in total
    applyStimulus(I_LW, 1'b0, 1'b0);
    checkOutput("lw_if", QUIET);
    checkOutput("lw_id", QUIET);
    checkOutput("lw_ex", ctl(0, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      checkOutput("lw_mem_wait", ctl(0, 1, 0, 0, 4'b0010, 0, 1, 0, 0, 0));
    end
    mem_ready = 1'b1;
    checkOutput("lw_mem_ready", ctl(0, 1, 0, 0, 4'b0010, 0, 1, 0, 0, 0));
    mem_ready = 1'b0;
    checkOutput("lw_wb", ctl(0, 1, 1, 1, 4'b0010, 1, 0, 0, 0, 0));

    // SW completing on its first MEM cycle
    applyStimulus(I_SW, 1'b0, 1'b1);
    checkOutput("sw_if", QUIET);
    checkOutput("sw_id", QUIET);
    checkOutput("sw_ex", ctl(0, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    checkOutput("sw_mem_done", ctl(0, 1, 0, 0, 4'b0010, 1, 0, 1, 0, 0));

    // BEQ, taken then not taken
    applyStimulus(I_BEQ, 1'b1, 1'b0);
    checkOutput("beq_t_if", QUIET);
    checkOutput("beq_t_id", QUIET);
    checkOutput("beq_t_ex", ctl(1, 0, 0, 0, 4'b0110, 1, 0, 0, 0, 0));
    applyStimulus(I_BEQ, 1'b0, 1'b0);
    checkOutput("beq_n_if", QUIET);
    checkOutput("beq_n_id", QUIET);
    checkOutput("beq_n_ex", ctl(0, 0, 0, 0, 4'b0110, 1, 0, 0, 0, 0));

    // Unsupported opcode, then ADD restarts cleanly from IF
    applyStimulus(I_BAD, 1'b0, 1'b0);
    checkOutput("bad_if", QUIET);
    checkOutput("bad_id", ctl(0, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 0));
    applyStimulus(I_ADD, 1'b0, 1'b0);
    checkOutput("after_bad_if", QUIET);
    checkOutput("after_bad_id", QUIET);
    checkOutput("after_bad_ex", ctl(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    checkOutput("after_bad_wb", ctl(0, 0, 1, 0, 4'b0010, 1, 0, 0, 0, 0));

    // Reset during the MEM phase of a LW
    applyStimulus(I_LW, 1'b0, 1'b0);
    checkOutput("abort_if", QUIET);
    checkOutput("abort_id", QUIET);
    checkOutput("abort_ex", ctl(0, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    checkOutput("abort_mem", ctl(0, 1, 0, 0, 4'b0010, 0, 1, 0, 0, 0));
    rst = 1'b1;
    checkOutput("abort_mem_rst", ctl(0, 1, 0, 0, 4'b0010, 0, 1, 0, 0, 0));
    rst = 1'b0;
    applyStimulus(I_SUB, 1'b0, 1'b0);
    checkOutput("abort_after_if", QUIET);
    checkOutput("abort_after_id", QUIET);
    checkOutput("abort_after_ex", ctl(0, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 0));
    checkOutput("abort_after_wb", ctl(0, 0, 1, 0, 4'b0110, 1, 0, 0, 0, 0));

    // SW that never completes: 16 MEM cycles, then HALT until reset
    applyStimulus(I_SW, 1'b0, 1'b0);
    checkOutput("sw_to_if", QUIET);
    checkOutput("sw_to_id", QUIET);
    checkOutput("sw_to_ex", ctl(0, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      checkOutput("sw_to_mem", ctl(0, 1, 0, 0, 4'b0010, 0, 0, 1, 0, 0));
    end
    checkOutput("halt_1", ctl(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    applyStimulus(I_ADD, 1'b1, 1'b1);
    checkOutput("halt_2", ctl(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    rst = 1'b1;
    checkOutput("halt_rst", ctl(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    rst = 1'b0;
    applyStimulus(I_ADD, 1'b0, 1'b0);
    checkOutput("post_halt_if", QUIET);
    checkOutput("post_halt_id", QUIET);
    checkOutput("post_halt_ex", ctl(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0));
    checkOutput("post_halt_wb", ctl(0, 0, 1, 0, 4'b0010, 1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
